lc_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single lower-cache (LC) port between the L1 data cache and the L1 instruction cache. Grants requests round-robin into a one-entry registered output stage, tracks outstanding line reads in an in-order ID FIFO, and steers each LC read response back to the requester that issued it. LC writes (L1D writebacks) are posted and take no response.

---
 rtl/lc_port_arbiter_if.sv | 67 ++++++
 rtl/lc_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_lc_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc_port_arbiter_if.sv
// Request, downstream and response handshake bundle between the L1 caches and the LC port.
// The slave modport is the arbiter's view; the master modport drives the arbiter.
interface lc_port_arbiter_if #(
    parameter int unsigned PADDR_BITS = 22,
    parameter int unsigned LINE_BITS  = 512
);
    logic                  d_valid_in;
    logic                  d_ready_out;
    logic [PADDR_BITS-1:0] d_addr_in;
    logic [LINE_BITS-1:0]  d_value_in;
    logic                  d_we_in;

    logic                  i_valid_in;
    logic                  i_ready_out;
    logic [PADDR_BITS-1:0] i_addr_in;

    logic                  lc_valid_out;
    logic                  lc_ready_in;
    logic [PADDR_BITS-1:0] lc_addr_out;
    logic [LINE_BITS-1:0]  lc_value_out;
    logic                  lc_we_out;

    logic                  lc_valid_in;
    logic                  lc_ready_out;
    logic [PADDR_BITS-1:0] lc_addr_in;
    logic [LINE_BITS-1:0]  lc_value_in;

    logic                  d_resp_valid_out;
    logic                  d_resp_ready_in;
    logic [PADDR_BITS-1:0] d_resp_addr_out;
    logic [LINE_BITS-1:0]  d_resp_value_out;

    logic                  i_resp_valid_out;
    logic                  i_resp_ready_in;
    logic [PADDR_BITS-1:0] i_resp_addr_out;
    logic [LINE_BITS-1:0]  i_resp_value_out;

    logic                  err_out;

    modport slave (
        input  d_valid_in, d_addr_in, d_value_in, d_we_in,
        input  i_valid_in, i_addr_in,
        input  lc_ready_in,
        input  lc_valid_in, lc_addr_in, lc_value_in,
        input  d_resp_ready_in, i_resp_ready_in,
        output d_ready_out, i_ready_out,
        output lc_valid_out, lc_addr_out, lc_value_out, lc_we_out,
        output lc_ready_out,
        output d_resp_valid_out, d_resp_addr_out, d_resp_value_out,
        output i_resp_valid_out, i_resp_addr_out, i_resp_value_out,
        output err_out
    );

    modport master (
        output d_valid_in, d_addr_in, d_value_in, d_we_in,
        output i_valid_in, i_addr_in,
        output lc_ready_in,
        output lc_valid_in, lc_addr_in, lc_value_in,
        output d_resp_ready_in, i_resp_ready_in,
        input  d_ready_out, i_ready_out,
        input  lc_valid_out, lc_addr_out, lc_value_out, lc_we_out,
        input  lc_ready_out,
        input  d_resp_valid_out, d_resp_addr_out, d_resp_value_out,
        input  i_resp_valid_out, i_resp_addr_out, i_resp_value_out,
        input  err_out
    );
endinterface

// File: rtl/lc_port_arbiter.sv
// Round-robin L1D/L1I arbiter for the shared LC port: one registered request stage,
// an in-order ID FIFO of outstanding line reads, and combinational response steering.
module lc_port_arbiter #(
    parameter int unsigned PADDR_BITS = 22,
    parameter int unsigned LINE_BITS  = 512,
    parameter int unsigned DEPTH      = 4
) (
    input  logic              clk_in,
    input  logic              rst_N_in,
    lc_port_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic        ID_D  = 1'b0;
    localparam logic        ID_I  = 1'b1;

    typedef struct packed {
        logic [PADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0]  value;
        logic                  we;
    } req_t;

    logic             out_valid;
    req_t             out_req;
    logic             last_grant_i;
    logic             err;

    logic [DEPTH-1:0] id_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             load_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic             d_elig;
    logic             i_elig;
    logic             grant_d;
    logic             grant_i;
    logic             push;
    logic             pop;
    logic             head_id;
    logic             lc_ready;
    req_t             next_req;

    // Grant selection: last_grant_i breaks ties so the other requester wins next.
    always_comb begin : grant_sel
        load_en   = !out_valid || bus.lc_ready_in;
        fifo_full = (count == CNT_W'(DEPTH));
        d_elig    = bus.d_valid_in && (bus.d_we_in || !fifo_full);
        i_elig    = bus.i_valid_in && !fifo_full;
        grant_d   = load_en && d_elig && (!i_elig || last_grant_i);
        grant_i   = load_en && i_elig && (!d_elig || !last_grant_i);
        push      = (grant_d && !bus.d_we_in) || grant_i;

        next_req       = '0;
        next_req.addr  = bus.i_addr_in;
        if (grant_d) begin
            next_req.addr  = bus.d_addr_in;
            next_req.value = bus.d_value_in;
            next_req.we    = bus.d_we_in;
        end
    end

    // Response steering by FIFO head; stray responses are absorbed and flagged.
    always_comb begin : resp_steer
        fifo_empty           = (count == '0);
        head_id              = id_mem[rd_ptr];
        lc_ready             = 1'b0;
        bus.d_ready_out      = 1'b0;
        bus.i_ready_out      = 1'b0;
        bus.d_resp_valid_out = 1'b0;
        bus.i_resp_valid_out = 1'b0;
        if (rst_N_in) begin
            bus.d_ready_out = grant_d;
            bus.i_ready_out = grant_i;
            if (fifo_empty) begin
                lc_ready = 1'b1;
            end else begin
                bus.d_resp_valid_out = bus.lc_valid_in && (head_id == ID_D);
                bus.i_resp_valid_out = bus.lc_valid_in && (head_id == ID_I);
                lc_ready = (head_id == ID_I) ? bus.i_resp_ready_in : bus.d_resp_ready_in;
            end
        end
        bus.lc_ready_out = lc_ready;
        pop              = !fifo_empty && bus.lc_valid_in && lc_ready;
    end

    assign bus.lc_valid_out     = out_valid;
    assign bus.lc_addr_out      = out_req.addr;
    assign bus.lc_value_out     = out_req.value;
    assign bus.lc_we_out        = out_req.we;
    assign bus.d_resp_addr_out  = bus.lc_addr_in;
    assign bus.d_resp_value_out = bus.lc_value_in;
    assign bus.i_resp_addr_out  = bus.lc_addr_in;
    assign bus.i_resp_value_out = bus.lc_value_in;
    assign bus.err_out          = err;

    // Output stage reloads whenever it is empty or being drained this cycle.
    always_ff @(posedge clk_in or negedge rst_N_in) begin : out_stage
        if (!rst_N_in) begin
            out_valid    <= 1'b0;
            out_req      <= '0;
            last_grant_i <= 1'b1;
        end else if (load_en) begin
            out_valid <= grant_d || grant_i;
            if (grant_d || grant_i) begin
                out_req      <= next_req;
                last_grant_i <= grant_i;
            end
        end
    end

    // In-order requester ID FIFO; pop reads the head before any same-cycle push.
    always_ff @(posedge clk_in or negedge rst_N_in) begin : id_fifo
        if (!rst_N_in) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= grant_i ? ID_I : ID_D;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin : err_flag
        if (!rst_N_in) begin
            err <= 1'b0;
        end else if (fifo_empty && bus.lc_valid_in) begin
            err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lc_port_arbiter.sv
// Directed bench for lc_port_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_lc_port_arbiter;
    localparam int unsigned AB    = 22;
    localparam int unsigned LB    = 512;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    lc_port_arbiter_if #(.PADDR_BITS(AB), .LINE_BITS(LB)) bus ();

    lc_port_arbiter #(.PADDR_BITS(AB), .LINE_BITS(LB), .DEPTH(DEPTH)) dut (
        .clk_in   (clk),
        .rst_N_in (rst_n),
        .bus      (bus.slave)
    );

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: held request, outstanding read owners, arbitration memory.
    bit              q[$];
    logic            m_v, m_we, m_last_i, m_err;
    logic [AB-1:0]   m_a;
    logic [LB-1:0]   m_val;
    int              p_win;
    logic            p_load, p_pop, p_err;
    logic [AB-1:0]   p_a;
    logic [LB-1:0]   p_val;
    logic            p_we;
    logic            e_dr, e_ir, e_lr, e_drv, e_irv;

    task automatic model_reset();
        q.delete();
        m_v = 0; m_we = 0; m_a = '0; m_val = '0; m_last_i = 1; m_err = 0;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(negedge clk);
            p_load = 0; p_pop = 0; p_err = 0; p_win = -1;
            p_a = '0; p_val = '0; p_we = 0;
            e_dr = 0; e_ir = 0; e_lr = 0; e_drv = 0; e_irv = 0;
            if (!rst_n) begin
                model_reset();
            end else begin
                bit full, de, ie;
                full   = (q.size() == DEPTH);
                p_load = !m_v || bus.lc_ready_in;
                de     = bus.d_valid_in && (bus.d_we_in || !full);
                ie     = bus.i_valid_in && !full;
                if (p_load) begin
                    if (de && ie) p_win = m_last_i ? 0 : 1;
                    else if (de)  p_win = 0;
                    else if (ie)  p_win = 1;
                end
                e_dr = (p_win == 0);
                e_ir = (p_win == 1);
                if (p_win == 0) begin
                    p_a = bus.d_addr_in; p_val = bus.d_value_in; p_we = bus.d_we_in;
                end else if (p_win == 1) begin
                    p_a = bus.i_addr_in;
                end
                if (q.size() == 0) begin
                    e_lr  = 1;
                    p_err = bus.lc_valid_in;
                end else begin
                    e_drv = bus.lc_valid_in && (q[0] == 0);
                    e_irv = bus.lc_valid_in && (q[0] == 1);
                    e_lr  = q[0] ? bus.i_resp_ready_in : bus.d_resp_ready_in;
                    p_pop = bus.lc_valid_in && e_lr;
                end
            end
            chk("d_ready",      LB'(bus.d_ready_out),      LB'(e_dr));
            chk("i_ready",      LB'(bus.i_ready_out),      LB'(e_ir));
            chk("lc_valid_out", LB'(bus.lc_valid_out),     LB'(m_v));
            chk("lc_addr_out",  LB'(bus.lc_addr_out),      LB'(m_a));
            chk("lc_value_out", bus.lc_value_out,          m_val);
            chk("lc_we_out",    LB'(bus.lc_we_out),        LB'(m_we));
            chk("lc_ready_out", LB'(bus.lc_ready_out),     LB'(e_lr));
            chk("d_resp_valid", LB'(bus.d_resp_valid_out), LB'(e_drv));
            chk("i_resp_valid", LB'(bus.i_resp_valid_out), LB'(e_irv));
            chk("err_out",      LB'(bus.err_out),          LB'(m_err));
            if (e_drv) chk("d_resp_value", bus.d_resp_value_out, bus.lc_value_in);
            if (e_irv) chk("i_resp_addr",  LB'(bus.i_resp_addr_out), LB'(bus.lc_addr_in));
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (p_pop) void'(q.pop_front());
                if (p_win == 1 || (p_win == 0 && !p_we)) q.push_back(p_win == 1);
                if (p_load) begin
                    m_v = (p_win >= 0);
                    if (p_win >= 0) begin
                        m_a = p_a; m_val = p_val; m_we = p_we; m_last_i = (p_win == 1);
                    end
                end
                if (p_err) m_err = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.d_valid_in = 0; bus.d_addr_in = '0; bus.d_value_in = '0; bus.d_we_in = 0;
        bus.i_valid_in = 0; bus.i_addr_in = '0;
        bus.lc_ready_in = 1;
        bus.lc_valid_in = 0; bus.lc_addr_in = '0; bus.lc_value_in = '0;
        bus.d_resp_ready_in = 1; bus.i_resp_ready_in = 1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n = 0;
        idle();
        tick(); tick();
        #1;
        chk("rst lc_valid_out", LB'(bus.lc_valid_out), LB'(1'b0));
        chk("rst err_out",      LB'(bus.err_out),      LB'(1'b0));
        rst_n = 1;

        // Single D read and its response.
        tick();
        bus.d_valid_in = 1; bus.d_addr_in = AB'(22'h2000);
        #1 chk("t1 d_ready", LB'(bus.d_ready_out), LB'(1'b1));
        tick();
        bus.d_valid_in = 0;
        #1 chk("t1 lc_addr_out", LB'(bus.lc_addr_out), LB'(22'h2000));
        chk("t1 lc_we_out", LB'(bus.lc_we_out), LB'(1'b0));
        tick();
        bus.lc_valid_in = 1; bus.lc_addr_in = AB'(22'h2000); bus.lc_value_in = LB'(32'hDEADBEEF);
        #1 chk("t1 d_resp_valid", LB'(bus.d_resp_valid_out), LB'(1'b1));
        chk("t1 d_resp_value", bus.d_resp_value_out, LB'(32'hDEADBEEF));
        chk("t1 i_resp_valid", LB'(bus.i_resp_valid_out), LB'(1'b0));
        tick();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;

        // Both requesters held valid: D,I,D,I, then FIFO full.
        bus.d_valid_in = 1; bus.d_addr_in = AB'(22'h100);
        bus.i_valid_in = 1; bus.i_addr_in = AB'(22'h200);
        #1 chk("t2 g0 d_ready", LB'(bus.d_ready_out), LB'(1'b1));
        tick();
        #1 chk("t2 g1 i_ready", LB'(bus.i_ready_out), LB'(1'b1));
        chk("t2 addr0", LB'(bus.lc_addr_out), LB'(22'h100));
        tick();
        #1 chk("t2 g2 d_ready", LB'(bus.d_ready_out), LB'(1'b1));
        chk("t2 addr1", LB'(bus.lc_addr_out), LB'(22'h200));
        tick();
        #1 chk("t2 g3 i_ready", LB'(bus.i_ready_out), LB'(1'b1));
        chk("t2 addr2", LB'(bus.lc_addr_out), LB'(22'h100));
        tick();
        #1 chk("t3 full d_ready", LB'(bus.d_ready_out), LB'(1'b0));
        chk("t3 full i_ready", LB'(bus.i_ready_out), LB'(1'b0));
        bus.i_valid_in = 0;
        bus.d_we_in = 1; bus.d_addr_in = AB'(22'h5000); bus.d_value_in = LB'(64'h0123456789ABCDEF);
        #1 chk("t3 wb d_ready", LB'(bus.d_ready_out), LB'(1'b1));
        tick();
        bus.d_we_in = 0; bus.d_addr_in = AB'(22'h6000); bus.d_value_in = '0;
        bus.lc_valid_in = 1; bus.lc_value_in = LB'(8'h11);
        #1 chk("t3 wb lc_addr_out", LB'(bus.lc_addr_out), LB'(22'h5000));
        chk("t3 wb lc_we_out", LB'(bus.lc_we_out), LB'(1'b1));
        chk("t3 stalled d_ready", LB'(bus.d_ready_out), LB'(1'b0));
        tick();
        bus.lc_valid_in = 0;
        #1 chk("t3 after pop d_ready", LB'(bus.d_ready_out), LB'(1'b1));
        tick();
        bus.d_valid_in = 0;
        #1 chk("t3 read lc_addr_out", LB'(bus.lc_addr_out), LB'(22'h6000));
        for (int k = 0; k < 4; k++) begin
            bus.lc_valid_in = 1; bus.lc_value_in = LB'(k + 32);
            if (k == 0) begin
                #1 chk("t3 drain head I", LB'(bus.i_resp_valid_out), LB'(1'b1));
            end
            tick();
        end
        bus.lc_valid_in = 0;

        // D read then I read; I response back-pressured for two cycles.
        bus.d_valid_in = 1; bus.d_addr_in = AB'(22'h1000);
        tick();
        bus.d_valid_in = 0; bus.i_valid_in = 1; bus.i_addr_in = AB'(22'h3000);
        #1 chk("t4 i_ready", LB'(bus.i_ready_out), LB'(1'b1));
        tick();
        bus.i_valid_in = 0;
        bus.i_resp_ready_in = 0;
        bus.lc_valid_in = 1; bus.lc_addr_in = AB'(22'h1000); bus.lc_value_in = LB'(8'hA1);
        #1 chk("t4 lc_addr_out", LB'(bus.lc_addr_out), LB'(22'h3000));
        chk("t4 r0 d_resp_valid", LB'(bus.d_resp_valid_out), LB'(1'b1));
        chk("t4 r0 lc_ready_out", LB'(bus.lc_ready_out), LB'(1'b1));
        tick();
        bus.lc_addr_in = AB'(22'h3000); bus.lc_value_in = LB'(8'hB2);
        for (int k = 0; k < 2; k++) begin
            #1 chk("t4 r1 stall lc_ready_out", LB'(bus.lc_ready_out), LB'(1'b0));
            chk("t4 r1 i_resp_valid", LB'(bus.i_resp_valid_out), LB'(1'b1));
            tick();
        end
        bus.i_resp_ready_in = 1;
        #1 chk("t4 r1 lc_ready_out", LB'(bus.lc_ready_out), LB'(1'b1));
        chk("t4 r1 i_resp_value", bus.i_resp_value_out, LB'(8'hB2));
        tick();
        bus.lc_valid_in = 0;

        // Downstream back-pressure holds the payload stable.
        bus.d_valid_in = 1; bus.d_we_in = 1; bus.d_addr_in = AB'(22'h7000); bus.d_value_in = LB'(16'hCAFE);
        bus.i_valid_in = 1; bus.i_addr_in = AB'(22'h8000);
        #1 chk("t5 d_ready", LB'(bus.d_ready_out), LB'(1'b1));
        tick();
        bus.lc_ready_in = 0; bus.d_addr_in = AB'(22'h7100);
        for (int k = 0; k < 3; k++) begin
            #1 chk("t5 hold lc_addr_out", LB'(bus.lc_addr_out), LB'(22'h7000));
            chk("t5 hold lc_value_out", bus.lc_value_out, LB'(16'hCAFE));
            chk("t5 hold d_ready", LB'(bus.d_ready_out), LB'(1'b0));
            chk("t5 hold i_ready", LB'(bus.i_ready_out), LB'(1'b0));
            tick();
        end
        bus.lc_ready_in = 1;
        #1 chk("t5 release i_ready", LB'(bus.i_ready_out), LB'(1'b1));
        tick();
        bus.d_valid_in = 0; bus.d_we_in = 0; bus.i_valid_in = 0;
        #1 chk("t5 next lc_addr_out", LB'(bus.lc_addr_out), LB'(22'h8000));
        chk("t5 next lc_we_out", LB'(bus.lc_we_out), LB'(1'b0));
        tick();
        bus.lc_valid_in = 1;
        tick();
        bus.lc_valid_in = 0;

        // Stray response, then reset mid-traffic.
        bus.lc_valid_in = 1;
        #1 chk("t6 stray lc_ready_out", LB'(bus.lc_ready_out), LB'(1'b1));
        chk("t6 stray d_resp_valid", LB'(bus.d_resp_valid_out), LB'(1'b0));
        tick();
        bus.lc_valid_in = 0;
        #1 chk("t6 err_out", LB'(bus.err_out), LB'(1'b1));
        bus.d_valid_in = 1; bus.d_addr_in = AB'(22'h9000); bus.lc_ready_in = 0;
        tick();
        bus.lc_valid_in = 1;
        #1 chk("t6 pre-rst lc_valid_out", LB'(bus.lc_valid_out), LB'(1'b1));
        rst_n = 0;
        #1 chk("t6 rst lc_valid_out", LB'(bus.lc_valid_out), LB'(1'b0));
        chk("t6 rst lc_addr_out", LB'(bus.lc_addr_out), LB'(1'b0));
        chk("t6 rst err_out", LB'(bus.err_out), LB'(1'b0));
        chk("t6 rst d_ready", LB'(bus.d_ready_out), LB'(1'b0));
        chk("t6 rst lc_ready_out", LB'(bus.lc_ready_out), LB'(1'b0));
        chk("t6 rst d_resp_valid", LB'(bus.d_resp_valid_out), LB'(1'b0));
        tick();
        idle();
        tick();
        rst_n = 1;
        tick(); tick();
        #1 chk("end err_out", LB'(bus.err_out), LB'(1'b0));
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
